memwb_pipe: RTL and testbench
=============================

MEMWB_PIPE -- requirements
Module: memwb_pipe

Interface
REQ-001 Parameter DATA_W, 64, width of the writeback datapath.
REQ-002 Parameter ADDR_W, 5, destination register address width.
REQ-003 Parameter NSRC, 3, number of writeback result sources (ALU, MEM, LINK).
REQ-004 Parameter ZERO_REG, 31, register index whose writes are discarded (XZR).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 in_valid  input  1  upstream MEM-stage bundle valid.
REQ-008 in_ready  output  1  block can accept a bundle this cycle.
REQ-009 in_src  input  NSRC*DATA_W  packed result sources; slice k = source k.
REQ-010 in_sel  input  $clog2(NSRC)  writeback source select.
REQ-011 in_size  input  2  load size: 0 byte, 1 half, 2 word, 3 dword.
REQ-012 in_signed  input  1  sign-extend (1) or zero-extend (0) the load.
REQ-013 in_aw  input  ADDR_W  destination register.
REQ-014 in_regwrite  input  1  destination write enable.
REQ-015 flush  input  1  discard all held bundles.
REQ-016 out_valid  output  1  WB bundle valid.
REQ-017 out_ready  input  1  register file / downstream accepts bundle.
REQ-018 out_data, out_aw, out_regwrite  output  DATA_W, ADDR_W, 1  writeback bundle.
REQ-019 fwd_valid, fwd_aw, fwd_data  output  1, ADDR_W, DATA_W  forwarding copy of the WB bundle for the EX-stage hazard unit.

Function
REQ-020 Transfer occurs when in_valid & in_ready (input) or out_valid & out_ready (output) at a rising edge.
REQ-021 Result = in_src slice in_sel; when in_sel = MEM, result = low 8/16/32/64 bits of the MEM slice per in_size, extended per in_signed; in_sel >= NSRC yields 0.
REQ-022 Result is computed before registration; latency input transfer to out_valid = 1 cycle when the output slot is empty.
REQ-023 Storage = main register + one skid register; states EMPTY, ONE, TWO.
REQ-024 EMPTY: input transfer -> ONE.
REQ-025 ONE: input only -> TWO (if out_ready low) or ONE (if out_ready high, main reloaded); output only -> EMPTY; both -> ONE.
REQ-026 TWO: output transfer moves skid to main -> ONE; no input accepted.
REQ-027 in_ready is registered, = 1 in EMPTY and ONE, 0 in TWO; full throughput of one bundle per cycle while out_ready stays high.
REQ-028 Order preserved: bundles leave in acceptance order; out_* stable while out_valid & ~out_ready.
REQ-029 out_regwrite = stored regwrite & (stored aw != ZERO_REG) & out_valid.
REQ-030 fwd_valid = out_regwrite; fwd_aw = out_aw; fwd_data = out_data.
REQ-031 flush: next edge -> EMPTY, out_valid 0, in_ready 1; flush wins over a simultaneous input transfer (that bundle is dropped).
REQ-032 Held data registers not required to clear on flush; all valid/regwrite outputs must be 0.

Reset
REQ-033 While reset = 0: state EMPTY, in_ready 1, out_valid 0, out_regwrite 0, fwd_valid 0, out_data 0, out_aw 0.
REQ-034 Reset assertion mid-transfer discards all held bundles immediately (asynchronously); first accept possible on first rising edge after deassertion.

Structure
REQ-035 Package memwb_pkg holds wb_sel_e (WB_ALU=0, WB_MEM=1, WB_LINK=2), mem_size_e (SZ_B, SZ_H, SZ_W, SZ_D) and the state enum.
REQ-036 Sub-module load_extend (combinational: data, size, signed -> extended DATA_W result); all state in memwb_pipe.

Verification
REQ-037 MEM sel, MEM slice 0x..._80, SZ_B, signed=1 -> out_data 0xFFFF_FFFF_FFFF_FF80 one cycle later; signed=0 -> 0x80.
REQ-038 out_ready held 0, three back-to-back bundles A,B,C -> A,B accepted, in_ready 0 on C; release -> A,B,C delivered in order, none lost.
REQ-039 Streaming 100 bundles with out_ready=1 -> one output per cycle, in_ready never drops.
REQ-040 in_aw=31, in_regwrite=1, ALU data 0x1234 -> out_valid 1, out_regwrite 0, fwd_valid 0.
REQ-041 State TWO, flush with simultaneous in_valid -> next cycle out_valid 0, in_ready 1, dropped bundle never appears.
REQ-042 reset pulsed low in state ONE between edges -> out_valid and out_regwrite 0 immediately, in_ready 1.

Source files
------------

// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB writeback pipeline slice.
package memwb_pkg;

  // Writeback result source select
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // Load access size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  // Occupancy of the main + skid storage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/memwb_pipe_if.sv
// Handshake and data bundle between MEM stage, writeback stage and hazard unit.
interface memwb_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3
);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [NSRC*DATA_W-1:0] in_src;
  logic [SEL_W-1:0]       in_sel;
  logic [1:0]             in_size;
  logic                   in_signed;
  logic [ADDR_W-1:0]      in_aw;
  logic                   in_regwrite;
  logic                   flush;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [ADDR_W-1:0]      out_aw;
  logic                   out_regwrite;

  logic                   fwd_valid;
  logic [ADDR_W-1:0]      fwd_aw;
  logic [DATA_W-1:0]      fwd_data;

  // Upstream/downstream environment side
  modport master (
    output in_valid, in_src, in_sel, in_size, in_signed, in_aw, in_regwrite,
           flush, out_ready,
    input  in_ready, out_valid, out_data, out_aw, out_regwrite,
           fwd_valid, fwd_aw, fwd_data
  );

  // Pipeline register side
  modport slave (
    input  in_valid, in_src, in_sel, in_size, in_signed, in_aw, in_regwrite,
           flush, out_ready,
    output in_ready, out_valid, out_data, out_aw, out_regwrite,
           fwd_valid, fwd_aw, fwd_data
  );

endinterface

// File: rtl/memwb_pipe_load_extend.sv
// Load data narrowing: keeps the low byte/half/word/dword and sign- or
// zero-extends it to the full datapath width.
module load_extend
  import memwb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i,
  input  mem_size_e         size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] result_o
);

  // Select the access width and fill the upper bits with the extension bit
  always_comb begin
    result_o = data_i;
    case (size_i)
      SZ_B:    result_o = {{(DATA_W-8){signed_i & data_i[7]}}, data_i[7:0]};
      SZ_H:    result_o = {{(DATA_W-16){signed_i & data_i[15]}}, data_i[15:0]};
      SZ_W:    result_o = {{(DATA_W-32){signed_i & data_i[31]}}, data_i[31:0]};
      SZ_D:    result_o = data_i;
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register with a one-entry skid buffer. The writeback
// result is selected and extended before registration; the held bundle is
// presented to the register file and mirrored to the forwarding network.
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 3,
  parameter int ZERO_REG = 31
) (
  input logic          clk,
  input logic          reset,
  memwb_pipe_if.slave  bus
);

  wb_state_e         state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [ADDR_W-1:0] main_aw_q, skid_aw_q;
  logic              main_rw_q, skid_rw_q;

  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] result_d;
  logic              in_fire, out_fire, out_valid;
  logic              load_main, load_skid, main_from_skid;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data_i   (bus.in_src[int'(WB_MEM)*DATA_W +: DATA_W]),
    .size_i   (mem_size_e'(bus.in_size)),
    .signed_i (bus.in_signed),
    .result_o (mem_ext)
  );

  // Pick the writeback source; unused select codes produce zero
  always_comb begin
    result_d = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(bus.in_sel) == k) result_d = bus.in_src[k*DATA_W +: DATA_W];
    end
    if (int'(bus.in_sel) == int'(WB_MEM)) result_d = mem_ext;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  // Occupancy transitions and which storage register loads; flush overrides all
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) state_d = ST_EMPTY;
  end

  // Occupancy state and registered ready (low only while both slots are full)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Main and skid bundle storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_aw_q   <= '0;
      main_rw_q   <= 1'b0;
      skid_data_q <= '0;
      skid_aw_q   <= '0;
      skid_rw_q   <= 1'b0;
    end else begin
      if (load_main) begin
        main_data_q <= result_d;
        main_aw_q   <= bus.in_aw;
        main_rw_q   <= bus.in_regwrite;
      end else if (main_from_skid) begin
        main_data_q <= skid_data_q;
        main_aw_q   <= skid_aw_q;
        main_rw_q   <= skid_rw_q;
      end
      if (load_skid) begin
        skid_data_q <= result_d;
        skid_aw_q   <= bus.in_aw;
        skid_rw_q   <= bus.in_regwrite;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = main_data_q;
  assign bus.out_aw       = main_aw_q;
  assign bus.out_regwrite = main_rw_q & (main_aw_q != ADDR_W'(ZERO_REG)) & out_valid;
  assign bus.fwd_valid    = bus.out_regwrite;
  assign bus.fwd_aw       = main_aw_q;
  assign bus.fwd_data     = main_data_q;

endmodule

// File: tb/tb_memwb_pipe.sv
// Randomized self-checking bench for memwb_pipe against a two-entry FIFO model.
module tb_memwb_pipe;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  aw;
    logic        rw;
  } bundle_t;

  logic clk;
  logic reset;
  int   compareCount;
  int   mismatchCount;
  bundle_t modelQ[$];

  memwb_pipe_if #(.DATA_W(64), .ADDR_W(5), .NSRC(3)) bus ();

  memwb_pipe #(.DATA_W(64), .ADDR_W(5), .NSRC(3), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when it differs
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Writeback value derived from the source-select and load rules
  function automatic logic [63:0] refResult(input logic [191:0] src, input int sel,
                                            input int size, input bit sgn);
    logic [63:0] mem;
    logic [63:0] mask;
    int w;
    case (sel)
      0: return src[63:0];
      2: return src[191:128];
      1: begin
        mem = src[127:64];
        w = 8 << size;
        if (w == 64) return mem;
        mask = (64'd1 << w) - 64'd1;
        mem = mem & mask;
        if (sgn && mem[w-1]) mem = mem | ~mask;
        return mem;
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic applyStimulus(input bit valid, input int sel, input int size,
                               input bit sgn, input int aw, input bit rw,
                               input logic [191:0] src);
    bus.in_valid    = valid;
    bus.in_sel      = 2'(sel);
    bus.in_size     = 2'(size);
    bus.in_signed   = sgn;
    bus.in_aw       = 5'(aw);
    bus.in_regwrite = rw;
    bus.in_src      = src;
  endtask

  function automatic logic [191:0] randSrc();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyRandom(input bit valid);
    applyStimulus(valid, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 31)),
                  1'($urandom), randSrc());
  endtask

  // Compare all outputs with the model's view of the current occupancy
  task automatic expectState();
    bit expRw;
    checkOutput("in_ready", 64'(bus.in_ready), 64'(modelQ.size() < 2));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(modelQ.size() > 0));
    expRw = (modelQ.size() > 0) && modelQ[0].rw && (modelQ[0].aw != 5'd31);
    checkOutput("out_regwrite", 64'(bus.out_regwrite), 64'(expRw));
    checkOutput("fwd_valid", 64'(bus.fwd_valid), 64'(expRw));
    if (modelQ.size() > 0) begin
      checkOutput("out_data", bus.out_data, modelQ[0].data);
      checkOutput("out_aw", 64'(bus.out_aw), 64'(modelQ[0].aw));
      checkOutput("fwd_data", bus.fwd_data, modelQ[0].data);
      checkOutput("fwd_aw", 64'(bus.fwd_aw), 64'(modelQ[0].aw));
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit inFire, outFire;
    bundle_t b;
    @(negedge clk);
    expectState();
    inFire  = bus.in_valid && (modelQ.size() < 2);
    outFire = (modelQ.size() > 0) && bus.out_ready;
    b.data = refResult(bus.in_src, int'(bus.in_sel), int'(bus.in_size), bus.in_signed);
    b.aw   = bus.in_aw;
    b.rw   = bus.in_regwrite;
    @(posedge clk);
    if (bus.flush) begin
      modelQ.delete();
    end else begin
      if (outFire) void'(modelQ.pop_front());
      if (inFire) modelQ.push_back(b);
    end
    #1;
  endtask

  initial begin
    logic [191:0] src;
    int drops;
    compareCount  = 0;
    mismatchCount = 0;
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, '0);

    // Reset values while reset is held low
    #12;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_regwrite", 64'(bus.out_regwrite), 64'd0);
    checkOutput("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    checkOutput("rst_out_data", bus.out_data, 64'd0);
    checkOutput("rst_out_aw", 64'(bus.out_aw), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Signed and unsigned byte loads of 0x80
    bus.out_ready = 1'b1;
    src = randSrc();
    src[71:64] = 8'h80;
    applyStimulus(1'b1, 1, 0, 1'b1, 3, 1'b1, src);
    cycle();
    checkOutput("sext_byte", bus.out_data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1'b1, 1, 0, 1'b0, 4, 1'b1, src);
    cycle();
    checkOutput("zext_byte", bus.out_data, 64'h0000_0000_0000_0080);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, '0);
    cycle();

    // Backpressure: A and B held, C refused, then all three in order
    bus.out_ready = 1'b0;
    applyRandom(1'b1); cycle();
    applyRandom(1'b1); cycle();
    applyRandom(1'b1); cycle();
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Streaming: one bundle per cycle, ready never drops
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      applyRandom(1'b1);
      if (!bus.in_ready) drops++;
      cycle();
    end
    checkOutput("stream_ready_drops", 64'(drops), 64'd0);
    bus.in_valid = 1'b0;
    cycle();

    // Writes to the zero register are suppressed
    src = '0;
    src[63:0] = 64'h1234;
    applyStimulus(1'b1, 0, 3, 1'b0, 31, 1'b1, src);
    cycle();
    checkOutput("xzr_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("xzr_out_regwrite", 64'(bus.out_regwrite), 64'd0);
    checkOutput("xzr_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    checkOutput("xzr_data", bus.out_data, 64'h1234);
    bus.in_valid = 1'b0;
    cycle();

    // Flush from the full state wins over a simultaneous input
    bus.out_ready = 1'b0;
    applyRandom(1'b1); cycle();
    applyRandom(1'b1); cycle();
    applyRandom(1'b1);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset pulse between edges while one bundle is held
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 0, 0, 1'b0, 7, 1'b1, randSrc());
    cycle();
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("arst_out_regwrite", 64'(bus.out_regwrite), 64'd0);
    checkOutput("arst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    checkOutput("arst_in_ready", 64'(bus.in_ready), 64'd1);
    #1 reset = 1'b1;
    modelQ.delete();
    cycle();

    // Random traffic with backpressure and occasional flushes
    for (int i = 0; i < 300; i++) begin
      applyRandom(1'($urandom_range(0, 3) != 0));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
